// File: rtl/me_frame_sched.sv
// Frame scheduler for the me_double core: walks the macroblock grid in raster
// order, runs one req/ack search per MB, and streams results with a saturating SAD total.
module me_frame_sched #(
  parameter int MB_COLS = 4,
  parameter int MB_ROWS = 3,
  parameter int IDX_W   = 8,
  parameter int SUM_W   = 24,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [IDX_W-1:0] mb_x,
  output logic [IDX_W-1:0] mb_y,
  output logic             me_req,
  input  logic             me_ack,
  input  logic [15:0]      me_min_sad,
  input  logic [9:0]       me_min_mvec,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_sad,
  output logic [9:0]       res_mvec,
  output logic [IDX_W-1:0] res_mb_idx,
  output logic [SUM_W-1:0] frame_sad
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_X   = IDX_W'(MB_COLS - 1);
  localparam logic [IDX_W-1:0] LAST_Y   = IDX_W'(MB_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_REL,
    S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [IDX_W-1:0] mb_x_q, mb_x_d;
  logic [IDX_W-1:0] mb_y_q, mb_y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             me_req_q, me_req_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_sad_q, res_sad_d;
  logic [9:0]       res_mvec_q, res_mvec_d;
  logic [IDX_W-1:0] res_mb_idx_q, res_mb_idx_d;
  logic [SUM_W-1:0] frame_sad_q, frame_sad_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             abort_seen_q, abort_seen_d;

  logic             last_mb;
  logic             wdog_hit;
  logic [SUM_W:0]   sad_sum;

  assign last_mb  = (mb_x_q == LAST_X) && (mb_y_q == LAST_Y);
  assign wdog_hit = (wdog_q == WD_LIMIT);
  // One extra bit catches the carry so the total can clamp at all-ones.
  assign sad_sum  = {1'b0, frame_sad_q} + (SUM_W + 1)'(res_sad_q);

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q + 1'b1;
    mb_x_d       = mb_x_q;
    mb_y_d       = mb_y_q;
    idx_d        = idx_q;
    me_req_d     = me_req_q;
    res_valid_d  = res_valid_q;
    res_sad_d    = res_sad_q;
    res_mvec_d   = res_mvec_q;
    res_mb_idx_d = res_mb_idx_q;
    frame_sad_d  = frame_sad_q;
    done_d       = 1'b0;
    err_d        = err_q;
    abort_seen_d = abort_seen_q | (abort && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if (start) begin
          mb_x_d       = '0;
          mb_y_d       = '0;
          idx_d        = '0;
          frame_sad_d  = '0;
          err_d        = 1'b0;
          abort_seen_d = 1'b0;
          me_req_d     = 1'b1;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        // An ack arriving on the timeout cycle still counts as a good search.
        if (me_ack) begin
          res_sad_d    = me_min_sad;
          res_mvec_d   = me_min_mvec;
          res_mb_idx_d = idx_q;
          res_valid_d  = 1'b1;
          wdog_d       = '0;
          state_d      = S_OUT;
        end else if (wdog_hit) begin
          err_d    = 1'b1;
          me_req_d = 1'b0;
          wdog_d   = '0;
          state_d  = S_REL;
        end
      end

      S_OUT: begin
        wdog_d = '0;
        if (res_ready) begin
          frame_sad_d = sad_sum[SUM_W] ? {SUM_W{1'b1}} : sad_sum[SUM_W-1:0];
          res_valid_d = 1'b0;
          me_req_d    = 1'b0;
          state_d     = S_REL;
        end
      end

      S_REL: begin
        if (!me_ack) begin
          wdog_d = '0;
          if (err_q || abort_seen_q) begin
            state_d = S_IDLE;
          end else begin
            done_d  = last_mb;
            state_d = S_NEXT;
          end
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = S_IDLE;
        end
      end

      S_NEXT: begin
        wdog_d = '0;
        if (last_mb) begin
          state_d = S_IDLE;
        end else begin
          if (mb_x_q == LAST_X) begin
            mb_x_d = '0;
            mb_y_d = mb_y_q + 1'b1;
          end else begin
            mb_x_d = mb_x_q + 1'b1;
          end
          idx_d    = idx_q + 1'b1;
          me_req_d = 1'b1;
          state_d  = S_REQ;
        end
      end

      default: begin
        wdog_d   = '0;
        me_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wdog_q       <= '0;
      mb_x_q       <= '0;
      mb_y_q       <= '0;
      idx_q        <= '0;
      me_req_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sad_q    <= '0;
      res_mvec_q   <= '0;
      res_mb_idx_q <= '0;
      frame_sad_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      mb_x_q       <= mb_x_d;
      mb_y_q       <= mb_y_d;
      idx_q        <= idx_d;
      me_req_q     <= me_req_d;
      res_valid_q  <= res_valid_d;
      res_sad_q    <= res_sad_d;
      res_mvec_q   <= res_mvec_d;
      res_mb_idx_q <= res_mb_idx_d;
      frame_sad_q  <= frame_sad_d;
      done_q       <= done_d;
      err_q        <= err_d;
      abort_seen_q <= abort_seen_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign mb_x        = mb_x_q;
  assign mb_y        = mb_y_q;
  assign me_req      = me_req_q;
  assign res_valid   = res_valid_q;
  assign res_sad     = res_sad_q;
  assign res_mvec    = res_mvec_q;
  assign res_mb_idx  = res_mb_idx_q;
  assign frame_sad   = frame_sad_q;

endmodule

// File: tb/tb_me_frame_sched.sv
// Directed plus randomized bench for me_frame_sched on a 2x2 grid with a
// behavioural core model and a per-frame expected-result reference.
module tb_me_frame_sched;
  localparam int COLS    = 2;
  localparam int ROWS    = 2;
  localparam int NMB     = COLS * ROWS;
  localparam int IDX_W   = 8;
  localparam int SUM_W   = 17;
  localparam int TIMEOUT = 20;
  localparam int SAT     = (1 << SUM_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, err_timeout, me_req, res_valid;
  logic             me_ack = 1'b0;
  logic             res_ready = 1'b0;
  logic [IDX_W-1:0] mb_x, mb_y, res_mb_idx;
  logic [15:0]      me_min_sad = '0;
  logic [15:0]      res_sad;
  logic [9:0]       me_min_mvec = '0;
  logic [9:0]       res_mvec;
  logic [SUM_W-1:0] frame_sad;

  int n_checks = 0;
  int n_fail   = 0;
  int sad_tab[NMB];
  int ack_lat    = 5;
  int hang_idx   = -1;
  int ready_mode = 0;
  int hi_cnt = 0, lo_cnt = 0, stall_cnt = 0, done_cnt = 0, run_cnt = 0, last_run = 0;
  int got_idx[$];
  int got_sad[$];
  int got_mvec[$];
  logic             stalled_prev = 1'b0;
  logic             done_prev = 1'b0;
  logic [15:0]      prev_sad = '0;
  logic [9:0]       prev_mvec = '0;
  logic [IDX_W-1:0] prev_idx = '0;

  me_frame_sched #(
    .MB_COLS(COLS), .MB_ROWS(ROWS), .IDX_W(IDX_W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err_timeout(err_timeout), .mb_x(mb_x), .mb_y(mb_y), .me_req(me_req), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .res_valid(res_valid),
    .res_ready(res_ready), .res_sad(res_sad), .res_mvec(res_mvec),
    .res_mb_idx(res_mb_idx), .frame_sad(frame_sad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Core model, result consumer and protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    int cidx;
    cidx = int'(mb_y) * COLS + int'(mb_x);
    if (rst) begin
      me_ack = 1'b0;
      hi_cnt = 0;
      lo_cnt = 0;
    end else if (me_req) begin
      lo_cnt = 0;
      hi_cnt++;
      if (hi_cnt >= ack_lat && cidx != hang_idx) me_ack = 1'b1;
    end else begin
      hi_cnt = 0;
      if (me_ack) begin
        lo_cnt++;
        if (lo_cnt >= 2) begin
          me_ack = 1'b0;
          lo_cnt = 0;
        end
      end
    end
    if (cidx >= 0 && cidx < NMB) me_min_sad = 16'(sad_tab[cidx]);
    me_min_mvec = {5'(cidx), ~5'(cidx)};

    case (ready_mode)
      0: res_ready = 1'b1;
      1: begin
        if (res_valid) stall_cnt++;
        else stall_cnt = 0;
        res_ready = (stall_cnt >= 8);
      end
      default: res_ready = 1'($urandom_range(0, 1));
    endcase

    if (stalled_prev && res_valid && !rst) begin
      chk("stall_sad", res_sad, prev_sad);
      chk("stall_mvec", res_mvec, prev_mvec);
      chk("stall_idx", res_mb_idx, prev_idx);
      chk("stall_req", me_req, 1);
    end
    if (res_valid && res_ready && !rst) begin
      got_idx.push_back(int'(res_mb_idx));
      got_sad.push_back(int'(res_sad));
      got_mvec.push_back(int'(res_mvec));
    end
    stalled_prev = res_valid && !res_ready;
    prev_sad  = res_sad;
    prev_mvec = res_mvec;
    prev_idx  = res_mb_idx;

    if (done_prev) chk("busy_after_done", busy, 0);
    if (done) begin
      done_cnt++;
      chk("busy_with_done", busy, 1);
    end
    done_prev = done;

    if (me_req) run_cnt++;
    else if (run_cnt != 0) begin
      last_run = run_cnt;
      run_cnt  = 0;
    end
  end

  task automatic start_frame();
    got_idx.delete();
    got_sad.delete();
    got_mvec.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_req", me_req, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk("frame_ends", busy, 0);
  endtask

  task automatic check_frame(input int n, input int exp_done, input int exp_err);
    int sum;
    sum = 0;
    for (int i = 0; i < n; i++) sum += sad_tab[i];
    if (sum > SAT) sum = SAT;
    chk("n_results", got_idx.size(), n);
    for (int i = 0; i < n && i < got_idx.size(); i++) begin
      chk("res_idx", got_idx[i], i);
      chk("res_sad", got_sad[i], sad_tab[i]);
      chk("res_mvec", got_mvec[i], ((i % 32) * 32) + (31 - (i % 32)));
    end
    chk("frame_sad", frame_sad, sum);
    chk("done_cnt", done_cnt, exp_done);
    chk("err_timeout", err_timeout, exp_err);
    chk("req_low", me_req, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_req"}, me_req, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_xy"}, {mb_x, mb_y}, 0);
    chk({tag, "_res"}, {res_sad, res_mvec, res_mb_idx}, 0);
    chk({tag, "_fsad"}, frame_sad, 0);
  endtask

  initial begin
    for (int i = 0; i < NMB; i++) sad_tab[i] = 100 + i;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Abort while idle must not disturb the next frame.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    ready_mode = 0;
    start_frame();
    wait_idle();
    check_frame(4, 1, 0);

    // Consumer stalls 7 cycles on every result.
    ready_mode = 1;
    start_frame();
    wait_idle();
    check_frame(4, 1, 0);

    // Core hangs on MB 2.
    ready_mode = 0;
    hang_idx = 2;
    start_frame();
    wait_idle();
    check_frame(2, 0, 1);
    chk("timeout_len", (last_run >= TIMEOUT && last_run <= TIMEOUT + 2), 1);
    hang_idx = -1;
    repeat (4) tick();

    // Abort during the search of MB 1.
    start_frame();
    for (int i = 0; i < 300 && !(me_req && !me_ack && mb_x == 1 && mb_y == 0); i++) tick();
    chk("saw_req_mb1", (me_req && mb_x == 1 && mb_y == 0), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    check_frame(2, 0, 0);
    repeat (4) tick();

    // Reset while a result is pending.
    ready_mode = 1;
    start_frame();
    for (int i = 0; i < 300 && !(res_valid && res_mb_idx == 1); i++) tick();
    chk("saw_out_mb1", res_valid, 1);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    tick();
    ready_mode = 0;
    start_frame();
    wait_idle();
    check_frame(4, 1, 0);

    // Start while busy is ignored; start right after done restarts cleanly.
    start_frame();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && !done; i++) tick();
    chk("saw_done", done, 1);
    check_frame(4, 1, 0);
    tick();
    start_frame();
    chk("restart_fsad", frame_sad, 0);
    wait_idle();
    check_frame(4, 1, 0);

    // Randomized frames: random SADs, ack latency and consumer backpressure.
    for (int f = 0; f < 6; f++) begin
      ready_mode = 2;
      ack_lat = int'($urandom_range(1, 6));
      for (int i = 0; i < NMB; i++)
        sad_tab[i] = (f == 5) ? int'($urandom_range(40000, 65535)) : int'($urandom_range(0, 65535));
      start_frame();
      wait_idle();
      check_frame(4, 1, 0);
      repeat (2) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
